// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO family: width
// calculations for pointers and the occupancy count, plus the operation
// type used by the count update logic.
package sync_fifo_pkg;

  // Ceiling log2 of the entry count, usable in constant expressions.
  function automatic int unsigned clog2_depth(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

  // Read/write pointer width; pointers wrap naturally at DEPTH.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (clog2_depth(depth) < 1) ? 1 : clog2_depth(depth);
  endfunction

  // Occupancy width: one extra bit so that count can reach DEPTH.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return clog2_depth(depth) + 1;
  endfunction

  // Accepted operation in a cycle, encoded as {wr_acc, rd_acc}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

  // Status decodes of the registered count.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage array: synchronous write port, asynchronous read port.
// Contents are intentionally not reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store the incoming word on an accepted write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: combinational view of the addressed entry.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with almost-full/almost-empty thresholds,
// exported occupancy count and registered overflow/underflow pulses.
// Optional build macro: SYNC_FIFO_FWFT_EN selects first-word-fall-through
// read data; when undefined, dout is registered on each accepted read.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr,
  input  logic                      rd,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  // Elaboration-time parameter legality check.
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) || (AE_LEVEL < 1) ||
      (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH) || (DATA_W < 1))
  begin : g_bad_params
    $error("sync_fifo_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] dout_q;
  logic              rd_acc;
  logic              wr_acc;
  fifo_op_e          op;
  fifo_flags_t       flags;

  // Status flags decoded from the registered count.
  always_comb begin
    flags              = '0;
    flags.full         = (count == FULL_CNT);
    flags.empty        = (count == '0);
    flags.almost_full  = (count >= AF_CNT);
    flags.almost_empty = (count <= AE_CNT);
  end

  assign full         = flags.full;
  assign empty        = flags.empty;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;

  // Accept rules: a write into a full FIFO only succeeds alongside a read.
  always_comb begin
    rd_acc = rd & ~flags.empty;
    wr_acc = wr & (~flags.full | rd_acc);
    op     = fifo_op_e'({wr_acc, rd_acc});
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Pointers, occupancy count and error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      case (op)
        OP_WR:   count <= count + CNT_W'(1);
        OP_RD:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      overflow  <= wr & ~wr_acc;
      underflow <= rd & ~rd_acc;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Track the head word while it is presented, so dout holds it once empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dout_q <= '0;
    else if (!flags.empty) dout_q <= rdata;
  end

  // Head word falls through with no latency whenever data is present.
  always_comb begin
    dout = flags.empty ? dout_q : rdata;
  end
`else
  // Registered read: capture the head word on each accepted read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dout_q <= '0;
    else if (rd_acc) dout_q <= rdata;
  end

  // Output is the read register directly.
  always_comb begin
    dout = dout_q;
  end
`endif

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; the next generation of the team's fixed 8-bit, 16-deep FIFO.
- Adds configurable width and depth, almost-full/almost-empty thresholds, an exported occupancy count and overflow/underflow error pulses.
- Optional first-word-fall-through read mode.
- Sits between producer/consumer blocks in one clock domain; its count output is what the existing FIFO assertion checker binds to.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=4.
- AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- wr  in  1  write request.
- rd  in  1  read request.
- din  in  DATA_W  write data.
- dout  out  DATA_W  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (rst low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, dout=0, overflow=0, underflow=0; empty=1, almost_empty=1, full=0, almost_full=0. Memory contents are not reset.
- Accept rules, evaluated on the same edge:
  - rd_acc = rd & ~empty.
  - wr_acc = wr & (~full | rd_acc). A write when full is accepted only if a read is accepted in the same cycle.
- Empty with wr and rd both high: the write is accepted, the read is rejected and underflow pulses.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither. count never exceeds DEPTH and never goes below 0.
- Flags are combinational decodes of the registered count, so they are valid in the cycle after the causing edge.
- Standard (registered) read:
  - On rd_acc, dout <= mem[rd_ptr] at that edge; data is visible one cycle after rd is sampled.
  - dout holds its value when no read is accepted.
- overflow <= wr & ~wr_acc; underflow <= rd & ~rd_acc. Both are registered single-cycle pulses, never sticky.
- Reset asserted mid-operation discards all contents and forces the reset values above; the first write after reset lands in mem[0].
- Parameter legality (DEPTH power of two, 0 < AE_LEVEL < AF_LEVEL <= DEPTH) is checked by an elaboration-time assertion.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through): dout continuously presents mem[rd_ptr] whenever ~empty, so the head word is valid with no read latency; rd_acc pops the entry and dout shows the next word in the following cycle. While empty, dout holds its last value. All accept rules and flags are unchanged.
- Undefined: registered read exactly as described under Behaviour.

Decomposition:
- Package sync_fifo_pkg:
  - function clog2_depth;
  - localparam-style helpers for pointer width (PTR_W) and count width (CNT_W).
- One sub-module, sync_fifo_mem: DEPTH x DATA_W storage with a synchronous write port and an asynchronous read port; the read-register/FWFT selection stays in the top.
- Control, pointers, count and flags live in sync_fifo_param.

Test Plan:
- Reset then 16 writes with DEPTH=16 (din 0x00..0x0F) -> count steps 1..16; almost_full at count 14; full=1 after the 16th; no overflow.
- Full, then wr=1 with din=0xAA and rd=0 for 1 cycle -> overflow pulses 1 cycle; count stays 16; 0xAA is never read back.
- Full, then wr=1 and rd=1 together with din=0x55 -> count stays 16; dout=0x00; 0x55 is read out last after 15 further reads.
- Drain 16 reads -> dout sequence 0x00..0x0F (1-cycle latency; 0 latency with SYNC_FIFO_FWFT_EN); then an extra rd -> underflow pulse, dout holds 0x0F.
- Empty, wr=1 and rd=1 with din=0x3C -> count=1, underflow pulses; the next rd returns 0x3C.
- 8 writes, then rst low for 2 ns off-edge -> count, flags and dout reset immediately (count=0, empty=1, dout=0); the next write/read returns the new data from mem[0].
